leaf_dispatch_rr: RTL and testbench

- Upstream feeder for the five se8 leaf instances under each se7 node.
- Accepts one valid/ready input stream and buffers it in a small FIFO.
- Hands each item to exactly one of NUM_OUT leaf consumers in round-robin order, skipping channels that are disabled.
- Keeps a wrapping count of items dispatched.

---
 rtl/leaf_dispatch_pkg.sv | 36 +++
 rtl/leaf_dispatch_rr_if.sv | 25 ++
 rtl/leaf_dispatch_fifo.sv | 53 +++++
 rtl/leaf_dispatch_rr.sv | 114 +++++++++++
 tb/tb_leaf_dispatch_rr.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/leaf_dispatch_pkg.sv
// Shared types, defaults and the round-robin search used by the leaf dispatcher.
// The search is sized for up to MAX_OUT channels; callers zero-extend their narrower vectors.
package leaf_dispatch_pkg;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_NUM_OUT = 5;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_CNT_W   = 16;

    localparam int unsigned MAX_OUT = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {IDLE, OFFER} disp_state_t;

    // First enabled channel strictly after cur, wrapping at num_out; returns cur when none is enabled.
    function automatic logic [IDX_W-1:0] next_enabled(
        input logic [IDX_W-1:0]   cur,
        input logic [MAX_OUT-1:0] enable_mask,
        input int unsigned        num_out
    );
        logic [IDX_W-1:0] res;
        logic             found;
        int unsigned      idx;
        res   = cur;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_OUT; i++) begin
            idx = (32'(cur) + i) % num_out;
            if (!found && (i <= num_out) && enable_mask[idx[IDX_W-1:0]]) begin
                res   = idx[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/leaf_dispatch_rr_if.sv
// Upstream valid/ready stream plus the per-channel leaf offer bus.
interface leaf_dispatch_rr_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_OUT = 5
) ();

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [NUM_OUT-1:0] ch_enable;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic [DATA_W-1:0]  out_data;

    modport master (
        output in_valid, in_data, ch_enable, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, ch_enable, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/leaf_dispatch_fifo.sv
// Small synchronous FIFO with occupancy count; full is judged on the registered count,
// so a same-cycle pop never makes room for a push.
module leaf_dispatch_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/leaf_dispatch_rr.sv
// Buffers one upstream stream and offers each item to exactly one enabled leaf channel,
// rotating round-robin; keeps a wrapping count of completed transfers.
module leaf_dispatch_rr
    import leaf_dispatch_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned NUM_OUT = DEF_NUM_OUT,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    localparam int unsigned FC_W   = $clog2(DEPTH) + 1,
    localparam int unsigned TGT_W  = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    leaf_dispatch_rr_if.slave  bus,
    output logic [FC_W-1:0]    fifo_count,
    output logic [TGT_W-1:0]   target,
    output logic [CNT_W-1:0]   sent_count
);

    localparam logic [TGT_W-1:0] TGT_RST = TGT_W'(NUM_OUT - 1);

    disp_state_t        state;
    disp_state_t        state_nxt;
    logic [TGT_W-1:0]   target_nxt;
    logic [TGT_W-1:0]   cand;
    logic [IDX_W-1:0]   cur_ext;
    logic [IDX_W-1:0]   cand_ext;
    logic [MAX_OUT-1:0] mask_ext;
    logic [NUM_OUT-1:0] out_valid_q;
    logic [DATA_W-1:0]  head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               any_en;
    logic               pop;

    leaf_dispatch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (bus.in_valid),
        .push_data (bus.in_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.in_ready  = !fifo_full;
    assign bus.out_data  = head;
    assign bus.out_valid = out_valid_q;
    assign any_en        = |bus.ch_enable;
    assign pop           = (state == OFFER) && bus.out_ready[target];

    always_comb begin
        cur_ext                = '0;
        cur_ext[TGT_W-1:0]     = target;
        mask_ext               = '0;
        mask_ext[NUM_OUT-1:0]  = bus.ch_enable;
        cand_ext               = next_enabled(cur_ext, mask_ext, NUM_OUT);
        cand                   = cand_ext[TGT_W-1:0];
    end

    // out_valid is decoded from registered state so an async reset withdraws it at once.
    always_comb begin
        out_valid_q = '0;
        if (state == OFFER) out_valid_q[target] = 1'b1;
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        case (state)
            IDLE: begin
                if (!fifo_empty && any_en) begin
                    state_nxt  = OFFER;
                    target_nxt = cand;
                end
            end
            OFFER: begin
                // Items remaining after this pop exclude a push landing on the same edge.
                if (pop) begin
                    if ((fifo_count > FC_W'(1)) && any_en) begin
                        target_nxt = cand;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= TGT_RST;
            sent_count <= '0;
        end else if (flush) begin
            state      <= IDLE;
            target     <= TGT_RST;
        end else begin
            state      <= state_nxt;
            target     <= target_nxt;
            if (pop) sent_count <= sent_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_leaf_dispatch_rr.sv
// Randomised and directed checks of leaf_dispatch_rr against a queue-based reference model.
module tb_leaf_dispatch_rr;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 5;
    localparam int unsigned D  = 4;
    localparam int unsigned CW = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush;
    logic [2:0]  fifo_count;
    logic [2:0]  target;
    logic [15:0] sent_count;

    leaf_dispatch_rr_if #(.DATA_W(DW), .NUM_OUT(N)) bus ();

    leaf_dispatch_rr #(
        .DATA_W  (DW),
        .NUM_OUT (N),
        .DEPTH   (D),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus.slave),
        .fifo_count (fifo_count),
        .target     (target),
        .sent_count (sent_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mq[$];
    bit          m_off;
    int          m_tgt;
    int          m_sent;
    int          total;
    int          bad;
    int          step_no;
    int          first_valid;
    int          grants[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_next(input int cur, input logic [N-1:0] en);
        for (int k = 1; k <= int'(N); k++) begin
            if (en[(cur + k) % N]) return (cur + k) % N;
        end
        return cur;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_off  = 1'b0;
        m_tgt  = N - 1;
        m_sent = 0;
    endtask

    task automatic compare_all();
        logic [N-1:0] ev;
        ev = '0;
        if (m_off) ev[m_tgt] = 1'b1;
        check("fifo_count", fifo_count, mq.size());
        check("in_ready", bus.in_ready, mq.size() < D);
        check("out_valid", bus.out_valid, ev);
        check("target", target, m_tgt);
        check("sent_count", sent_count, m_sent);
        if (m_off) check("out_data", bus.out_data, mq[0]);
    endtask

    task automatic step();
        logic [N-1:0] acc_v;
        bit           acc;
        bit           push;
        int           remaining;
        acc_v = bus.out_valid & bus.out_ready;
        if (!flush) begin
            for (int i = 0; i < int'(N); i++) if (acc_v[i]) grants.push_back(i);
        end
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_off = 1'b0;
            m_tgt = N - 1;
        end else begin
            acc       = m_off && bus.out_ready[m_tgt];
            push      = bus.in_valid && (mq.size() < D);
            remaining = mq.size() - int'(acc);
            if (!m_off || acc) begin
                if (remaining > 0 && bus.ch_enable != '0) begin
                    m_tgt = m_next(m_tgt, bus.ch_enable);
                    m_off = 1'b1;
                end else begin
                    m_off = 1'b0;
                end
            end
            if (acc) begin
                void'(mq.pop_front());
                m_sent = (m_sent + 1) % 65536;
            end
            if (push) mq.push_back(bus.in_data);
        end
        step_no++;
        #1;
        compare_all();
        if (first_valid < 0 && bus.out_valid != '0) first_valid = step_no;
    endtask

    task automatic push_items(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + 32'(i);
            step();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while ((m_off || mq.size() > 0) && n < max) begin
            step();
            n++;
        end
        if (n >= max) check("drain_timeout", 1, 0);
    endtask

    task automatic check_grants(input string tag, input int exp[$]);
        check({tag, "_n"}, grants.size(), exp.size());
        for (int i = 0; i < exp.size() && i < grants.size(); i++) check(tag, grants[i], exp[i]);
    endtask

    initial begin
        int exp_q[$];
        int push_step;
        int saved;
        total = 0; bad = 0; step_no = 0; first_valid = -1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.ch_enable = '1;
        bus.out_ready = '1;
        model_reset();
        #1 rst_n = 1'b0;
        #10;
        compare_all();
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", bus.in_ready, 1);

        // all channels, consecutive pushes
        grants.delete();
        push_step = step_no;
        first_valid = -1;
        push_items(7, 32'hA0);
        drain(30);
        check("first_valid_cycle", first_valid, push_step + 2);
        exp_q = '{0, 1, 2, 3, 4, 0, 1};
        check_grants("grant_all", exp_q);
        check("sent_7", sent_count, 7);
        check("fifo_empty_7", fifo_count, 0);

        // sparse enable mask
        bus.ch_enable = 5'b10100;
        grants.delete();
        push_items(4, 32'hB0);
        drain(30);
        exp_q = '{2, 4, 2, 4};
        check_grants("grant_sparse", exp_q);

        // nothing enabled: FIFO fills and backpressures
        bus.ch_enable = '0;
        grants.delete();
        push_items(6, 32'hC0);
        check("full_count", fifo_count, 4);
        check("full_in_ready", bus.in_ready, 0);
        check("full_no_offer", bus.out_valid, 0);
        bus.ch_enable = 5'b00010;
        drain(30);
        exp_q = '{1, 1, 1, 1};
        check_grants("grant_ch1", exp_q);
        check("ready_back", bus.in_ready, 1);

        // stalled offer to ch0 while ch1 is ready
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.ch_enable = '1;
        bus.out_ready = 5'b00010;
        grants.delete();
        push_items(1, 32'hD0);
        step();
        for (int i = 0; i < 5; i++) step();
        check("stall_valid", bus.out_valid, 5'b00001);
        check("stall_data", bus.out_data, 32'hD0);
        check("stall_no_grant", grants.size(), 0);
        bus.out_ready = '1;
        drain(10);
        exp_q = '{0};
        check_grants("grant_stall", exp_q);

        // flush with buffered items and a concurrent push
        bus.ch_enable = '0;
        push_items(3, 32'hE0);
        saved = m_sent;
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hEE;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_count", fifo_count, 0);
        check("flush_valid", bus.out_valid, 0);
        check("flush_sent", sent_count, saved);
        bus.ch_enable = '1;
        grants.delete();
        push_items(1, 32'hF0);
        drain(10);
        exp_q = '{0};
        check_grants("grant_flush", exp_q);

        // async reset while offering with a full FIFO
        bus.out_ready = '0;
        push_items(4, 32'h100);
        step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_sent", sent_count, 0);
        check("rst_target", target, N - 1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = '1;

        // randomised traffic
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = $urandom;
            bus.ch_enable = ($urandom_range(0, 7) == 0) ? 5'b0 : 5'($urandom);
            bus.out_ready = 5'($urandom) | 5'($urandom);
            flush         = ($urandom_range(0, 29) == 0);
            step();
        end
        flush = 1'b0;
        bus.ch_enable = '1;
        bus.out_ready = '1;
        drain(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
